// File: rtl/router_pkg.sv
// Shared types for the router packet-reception controller: state encoding,
// default geometry and the destination-address validity helper.
package router_pkg;

   localparam int NUM_PORTS_DEF = 3;
   localparam int ADDR_W_DEF    = 2;
   localparam int DROP_W_DEF    = 8;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   // A header addresses a FIFO only if it falls inside 0..numPorts-1.
   function automatic logic isInvalidAddr(input int addr, input int numPorts);
      return addr >= numPorts;
   endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Packet-reception controller: sequences header decode, payload load, full stall
// and parity handling, and counts headers dropped for an out-of-range address.
module router_ctrl_fsm
   import router_pkg::*;
#(
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DROP_W    = DROP_W_DEF
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   input  logic                 parity_done,
   input  logic                 low_pkt_valid,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 full_state,
   output logic                 write_enb_reg,
   output logic                 rst_int_reg,
   output logic                 busy,
   output logic [DROP_W-1:0]    drop_cnt
);

   localparam int PAD_W = 2 ** ADDR_W;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   dest_q, dest_d;
   logic [DROP_W-1:0]   drop_q, drop_d;

   // Padding to the full address space makes invalid addresses read as
   // "not empty / no soft reset" instead of indexing past the port vectors.
   logic [PAD_W-1:0]    emptyPad;
   logic [PAD_W-1:0]    softPad;

   assign emptyPad = PAD_W'(fifo_empty);
   assign softPad  = PAD_W'(soft_reset);
   assign drop_cnt = drop_q;

   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      drop_d  = drop_q;
      if (state_q != DECODE_ADDRESS && softPad[dest_q]) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (pkt_valid) begin
                  dest_d = data_in;
                  if (isInvalidAddr(int'(data_in), NUM_PORTS)) begin
                     if (drop_q != '1) drop_d = drop_q + 1'b1;
                  end else if (emptyPad[data_in]) begin
                     state_d = LOAD_FIRST_DATA;
                  end else begin
                     state_d = WAIT_TILL_EMPTY;
                  end
               end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done)        state_d = DECODE_ADDRESS;
               else if (low_pkt_valid) state_d = LOAD_PARITY;
               else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
               if (emptyPad[dest_q]) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
         endcase
      end
   end

   // Strobes are registered from the next state so they line up with state_q.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q       <= DECODE_ADDRESS;
         dest_q        <= '0;
         drop_q        <= '0;
         detect_add    <= 1'b1;
         lfd_state     <= 1'b0;
         ld_state      <= 1'b0;
         laf_state     <= 1'b0;
         full_state    <= 1'b0;
         write_enb_reg <= 1'b0;
         rst_int_reg   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         dest_q        <= dest_d;
         drop_q        <= drop_d;
         detect_add    <= (state_d == DECODE_ADDRESS);
         lfd_state     <= (state_d == LOAD_FIRST_DATA);
         ld_state      <= (state_d == LOAD_DATA);
         laf_state     <= (state_d == LOAD_AFTER_FULL);
         full_state    <= (state_d == FIFO_FULL_STATE);
         write_enb_reg <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                          (state_d == LOAD_AFTER_FULL);
         rst_int_reg   <= (state_d == CHECK_PARITY_ERROR);
         busy          <= (state_d != DECODE_ADDRESS) && (state_d != LOAD_DATA);
      end
   end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: directed packet scenarios followed by
// randomized traffic, all checked against a phase-name reference model.
module tb_router_ctrl_fsm;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] soft_reset;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, busy;
   logic [7:0] drop_cnt;

   int    compared   = 0;
   int    mismatched = 0;
   string phase      = "DA";
   int    mDest      = 0;
   int    mDrop      = 0;

   always #5 clock = ~clock;

   router_ctrl_fsm dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
      .rst_int_reg(rst_int_reg), .busy(busy), .drop_cnt(drop_cnt)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One packet phase per rising edge, following the controller's rules in prose order.
   task automatic modelStep();
      if (!resetn) begin
         phase = "DA"; mDest = 0; mDrop = 0;
      end else if (phase != "DA" && mDest < 3 && soft_reset[mDest]) begin
         phase = "DA";
      end else begin
         case (phase)
            "DA": if (pkt_valid) begin
               mDest = int'(data_in);
               if (mDest >= 3) mDrop = (mDrop == 255) ? 255 : mDrop + 1;
               else phase = fifo_empty[mDest] ? "LFD" : "WTE";
            end
            "LFD": phase = "LD";
            "LD":  if (fifo_full) phase = "FFS"; else if (!pkt_valid) phase = "LP";
            "FFS": if (!fifo_full) phase = "LAF";
            "LAF": phase = parity_done ? "DA" : (low_pkt_valid ? "LP" : "LD");
            "LP":  phase = "CPE";
            "CPE": phase = fifo_full ? "FFS" : "DA";
            "WTE": if (fifo_empty[mDest]) phase = "LFD";
            default: phase = "DA";
         endcase
      end
   endtask

   function automatic logic [7:0] expStrobes();
      logic wr;
      wr = (phase == "LD") || (phase == "LP") || (phase == "LAF");
      return {phase == "DA", phase == "LFD", phase == "LD", phase == "LAF",
              phase == "FFS", wr, phase == "CPE", !(phase == "DA" || phase == "LD")};
   endfunction

   task automatic applyStimulus(input logic rn, input logic pv, input logic [1:0] din,
                                input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                                input logic pd, input logic lpv);
      @(negedge clock);
      resetn = rn; pkt_valid = pv; data_in = din; fifo_full = ff;
      fifo_empty = fe; soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
      @(posedge clock);
      modelStep();
      #2;
      checkOutput({"strobes_", phase},
                  int'({detect_add, lfd_state, ld_state, laf_state, full_state,
                        write_enb_reg, rst_int_reg, busy}), int'(expStrobes()));
      checkOutput("drop_cnt", int'(drop_cnt), mDrop);
   endtask

   task automatic step(input logic pv, input logic [1:0] din, input logic ff,
                       input logic [2:0] fe, input logic [2:0] sr);
      applyStimulus(1'b1, pv, din, ff, fe, sr, 1'b0, 1'b0);
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      checkOutput("reset_detect_add", int'(detect_add), 1);
      checkOutput("reset_busy", int'(busy), 0);

      // Header to port 1, full stall for three cycles, then parity and return.
      step(1'b1, 2'd1, 1'b0, 3'b111, 3'b000);
      checkOutput("hdr_lfd", int'(lfd_state), 1);
      step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000);
      checkOutput("hdr_ld", int'(ld_state), 1);
      for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 1'b1, 3'b101, 3'b000);
      checkOutput("full_no_write", int'(write_enb_reg), 0);
      step(1'b1, 2'd3, 1'b0, 3'b101, 3'b000);
      step(1'b1, 2'd1, 1'b0, 3'b101, 3'b000);
      step(1'b0, 2'd0, 1'b0, 3'b101, 3'b000);
      checkOutput("parity_write", int'(write_enb_reg), 1);
      step(1'b0, 2'd0, 1'b0, 3'b101, 3'b000);
      checkOutput("check_rst_int", int'(rst_int_reg), 1);
      step(1'b0, 2'd0, 1'b0, 3'b101, 3'b000);

      // Header to a busy port 2 waits five cycles before loading.
      step(1'b1, 2'd2, 1'b0, 3'b011, 3'b000);
      for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 1'b0, 3'b011, 3'b000);
      step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000);
      step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000);
      step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000);
      step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000);
      step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000);

      // Invalid-address headers saturate the drop counter.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 2'd3, 1'b0, 3'b111, 3'b000);
         step(1'b0, 2'd3, 1'b0, 3'b111, 3'b000);
      end
      checkOutput("drop_saturated", int'(drop_cnt), 255);

      // Soft reset of the selected port aborts a stalled packet.
      step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000);
      step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000);
      step(1'b1, 2'd0, 1'b1, 3'b110, 3'b000);
      step(1'b1, 2'd0, 1'b1, 3'b110, 3'b001);
      checkOutput("soft_abort_detect", int'(detect_add), 1);

      // Reset in the middle of a payload clears the drop counter.
      step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000);
      step(1'b1, 2'd1, 1'b0, 3'b111, 3'b000);
      step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000);
      applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      checkOutput("midpkt_reset_detect", int'(detect_add), 1);
      checkOutput("midpkt_reset_drop", int'(drop_cnt), 0);

      // Randomized traffic, including soft resets and rare hard resets.
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] sr;
         for (int b = 0; b < 3; b++) sr[b] = ($urandom_range(0, 31) == 0);
         applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                       2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                       3'($urandom_range(0, 7)), sr, ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
